imm_gen_unit: RTL and testbench

Immediate generator for the 20-bit pipelined core. It decodes the opcode of a 20-bit instruction word, extracts that format's immediate field and extends it to DATA_WIDTH. It registers the result for the next pipeline stage. It sits in the decode stage beside the register file; its output feeds the ALU operand mux, address adder and branch/jump target logic.

---
 rtl/imm_gen_if.sv | 20 ++
 rtl/imm_gen_unit.sv | 113 +++++++++++
 tb/tb_imm_gen_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Decode-stage immediate bus: instruction word in, extended immediate and flag out.
interface imm_gen_if #(
  parameter int unsigned DATA_WIDTH = 20
);
  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] immediate;
  logic                  imm_used;

  modport master (
    output instruction,
    input  immediate,
    input  imm_used
  );

  modport slave (
    input  instruction,
    output immediate,
    output imm_used
  );
endinterface

// File: rtl/imm_gen_unit.sv
// Immediate generator: decodes the opcode, extracts and extends the format's
// immediate field, and registers it for the next pipeline stage.
module imm_gen_unit #(
  parameter int unsigned DATA_WIDTH = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  imm_gen_if.slave   bus
);

  // Field positions are fixed for a 20-bit word; only DATA_WIDTH = 20 is meaningful.
  localparam int unsigned OP_W   = 4;
  localparam int unsigned I_W    = 8;
  localparam int unsigned S_W    = 8;
  localparam int unsigned B_W    = 9;
  localparam int unsigned J_W    = 12;
  localparam int unsigned U_PAD  = DATA_WIDTH - J_W;

  localparam logic [OP_W-1:0] OP_R_ALU  = 4'h0;
  localparam logic [OP_W-1:0] OP_I_ALU  = 4'h1;
  localparam logic [OP_W-1:0] OP_LOAD   = 4'h2;
  localparam logic [OP_W-1:0] OP_STORE  = 4'h3;
  localparam logic [OP_W-1:0] OP_BRANCH = 4'h4;
  localparam logic [OP_W-1:0] OP_JAL    = 4'h5;
  localparam logic [OP_W-1:0] OP_LUI    = 4'h6;
  localparam logic [OP_W-1:0] OP_JALR   = 4'h7;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;

  logic [OP_W-1:0]       opcode_c;
  logic                  sign_c;
  logic [2:0]            fmt_c;
  logic [I_W-1:0]        i_field_c;
  logic [S_W-1:0]        s_field_c;
  logic [B_W-1:0]        b_field_c;
  logic [J_W-1:0]        j_field_c;
  logic [DATA_WIDTH-1:0] i_ext_c;
  logic [DATA_WIDTH-1:0] s_ext_c;
  logic [DATA_WIDTH-1:0] b_ext_c;
  logic [DATA_WIDTH-1:0] j_ext_c;
  logic [DATA_WIDTH-1:0] u_ext_c;

  logic [DATA_WIDTH-1:0] immediate_d, immediate_q;
  logic                  imm_used_d,  imm_used_q;

  // Opcode to format; reserved opcodes fall through to "no immediate".
  always_comb begin
    opcode_c = bus.instruction[3:0];
    fmt_c    = FMT_NONE;
    unique case (opcode_c)
      OP_R_ALU:                   fmt_c = FMT_NONE;
      OP_I_ALU, OP_LOAD, OP_JALR: fmt_c = FMT_I;
      OP_STORE:                   fmt_c = FMT_S;
      OP_BRANCH:                  fmt_c = FMT_B;
      OP_JAL:                     fmt_c = FMT_J;
      OP_LUI:                     fmt_c = FMT_U;
      default:                    fmt_c = FMT_NONE;
    endcase
  end

  // Raw fields; every signed format shares the word's top bit as its sign.
  always_comb begin
    sign_c    = bus.instruction[19];
    i_field_c = bus.instruction[19:12];
    s_field_c = {bus.instruction[19:16], bus.instruction[7:4]};
    b_field_c = {s_field_c, 1'b0};
    j_field_c = bus.instruction[19:8];
  end

  always_comb begin
    i_ext_c = {{(DATA_WIDTH - I_W){sign_c}}, i_field_c};
    s_ext_c = {{(DATA_WIDTH - S_W){sign_c}}, s_field_c};
    b_ext_c = {{(DATA_WIDTH - B_W){sign_c}}, b_field_c};
    j_ext_c = {{(DATA_WIDTH - J_W){sign_c}}, j_field_c};
    u_ext_c = {j_field_c, U_PAD'(0)};
  end

  always_comb begin
    immediate_d = '0;
    imm_used_d  = 1'b0;
    unique case (fmt_c)
      FMT_I: begin immediate_d = i_ext_c; imm_used_d = 1'b1; end
      FMT_S: begin immediate_d = s_ext_c; imm_used_d = 1'b1; end
      FMT_B: begin immediate_d = b_ext_c; imm_used_d = 1'b1; end
      FMT_J: begin immediate_d = j_ext_c; imm_used_d = 1'b1; end
      FMT_U: begin immediate_d = u_ext_c; imm_used_d = 1'b1; end
      default: begin
        immediate_d = '0;
        imm_used_d  = 1'b0;
      end
    endcase
  end

  // Pipeline register; reset drops any in-flight value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      immediate_q <= '0;
      imm_used_q  <= 1'b0;
    end else begin
      immediate_q <= immediate_d;
      imm_used_q  <= imm_used_d;
    end
  end

  assign bus.immediate = immediate_q;
  assign bus.imm_used  = imm_used_q;

endmodule

// File: tb/tb_imm_gen_unit.sv
// Bench for imm_gen_unit: directed literal vectors plus a per-cycle
// comparison against a behavioural model of the immediate table.
module tb_imm_gen_unit;

  localparam int unsigned DW = 20;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   check_en;

  logic [DW-1:0] exp_imm;
  logic          exp_used;

  imm_gen_if #(.DATA_WIDTH(DW)) bus ();

  imm_gen_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec table computed with integer arithmetic: value of field, then two's complement.
  function automatic logic [DW:0] model(input logic [DW-1:0] w);
    int v;
    int n;
    bit signed_fmt;
    bit used;
    v = 0; n = 1; signed_fmt = 1'b1; used = 1'b1;
    case (int'(w[3:0]))
      1, 2, 7: begin v = int'(w[19:12]); n = 8; end
      3:       begin v = int'(w[19:16]) * 16 + int'(w[7:4]); n = 8; end
      4:       begin v = (int'(w[19:16]) * 16 + int'(w[7:4])) * 2; n = 9; end
      5:       begin v = int'(w[19:8]); n = 12; end
      6:       begin v = int'(w[19:8]) * 256; signed_fmt = 1'b0; end
      default: begin v = 0; used = 1'b0; signed_fmt = 1'b0; end
    endcase
    if (signed_fmt && v >= (1 << (n - 1))) v = v - (1 << n);
    return {used, DW'(v)};
  endfunction

  // Reference pipeline stage: what the outputs must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_imm  = '0;
      exp_used = 1'b0;
    end else begin
      {exp_used, exp_imm} = model(bus.instruction);
    end
  end

  task automatic compare(input string name, input logic [DW-1:0] act_imm,
                         input logic act_used, input logic [DW-1:0] req_imm,
                         input logic req_used);
    vectors++;
    if (act_imm !== req_imm || act_used !== req_used) begin
      miscompares++;
      $display("FAIL %s: got imm=%05h used=%b, want imm=%05h used=%b (instr=%05h t=%0t)",
               name, act_imm, act_used, req_imm, req_used, bus.instruction, $time);
    end
  endtask

  // Every-cycle model check, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (check_en) compare("model", bus.immediate, bus.imm_used, exp_imm, exp_used);
  end

  task automatic apply(input logic [DW-1:0] w);
    @(posedge clk);
    #2 bus.instruction = w;
  endtask

  task automatic apply_check(input string name, input logic [DW-1:0] w,
                             input logic [DW-1:0] req_imm, input logic req_used);
    apply(w);
    @(posedge clk);
    #1 compare(name, bus.immediate, bus.imm_used, req_imm, req_used);
  endtask

  logic [DW-1:0] image [10];

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    rst_n       = 1'b0;
    bus.instruction = 20'hFF001;
    image = '{20'h7F211, 20'h80212, 20'h5A0A3, 20'h800F4, 20'hABC05,
              20'h12306, 20'hFFFF0, 20'hFF007, 20'h3C0D4, 20'h0000C};

    // Reset held with a nonzero-immediate instruction present.
    repeat (3) @(posedge clk);
    #1 compare("reset_hold", bus.immediate, bus.imm_used, 20'h00000, 1'b0);
    check_en = 1'b1;
    #2 rst_n = 1'b1;

    // First edge after release captures the current instruction (0xFF001).
    @(posedge clk);
    #1 compare("post_reset", bus.immediate, bus.imm_used, 20'hFFFFF, 1'b1);

    apply_check("i_pos",    20'h7F211, 20'h0007F, 1'b1);
    apply_check("i_neg",    20'h80211, 20'hFFF80, 1'b1);
    apply_check("jalr",     20'hFF007, 20'hFFFFF, 1'b1);
    apply_check("store",    20'h5A0A3, 20'h0005A, 1'b1);
    apply_check("branch",   20'h5A0A4, 20'h000B4, 1'b1);
    apply_check("br_neg",   20'h800F4, 20'hFFF1E, 1'b1);
    apply_check("jal_neg",  20'hABC05, 20'hFFABC, 1'b1);
    apply_check("jal_pos",  20'h12305, 20'h00123, 1'b1);
    apply_check("lui",      20'hABC06, 20'hABC00, 1'b1);
    apply_check("load",     20'hC3452, 20'hFFFC3, 1'b1);
    apply_check("r_alu",    20'hFFFF0, 20'h00000, 1'b0);
    apply_check("reserved", 20'hFFFF9, 20'h00000, 1'b0);
    apply_check("rsv_f",    20'hFFFFF, 20'h00000, 1'b0);

    // Outputs hold steady while the input is unchanged.
    apply_check("hold_a", 20'h7F211, 20'h0007F, 1'b1);
    @(posedge clk);
    #1 compare("hold_b", bus.immediate, bus.imm_used, 20'h0007F, 1'b1);

    // Asynchronous mid-cycle reset clears outputs before the next edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 compare("async_rst", bus.immediate, bus.imm_used, 20'h00000, 1'b0);
    bus.instruction = 20'hABC06;
    @(posedge clk);
    #1 compare("rst_low_edge", bus.immediate, bus.imm_used, 20'h00000, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 compare("rst_release", bus.immediate, bus.imm_used, 20'hABC00, 1'b1);

    // Streaming: one word per cycle, checked by the model process.
    foreach (image[i]) apply(image[i]);
    for (int i = 0; i < 40; i++) apply(DW'($urandom));
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
